ldpc_enc_scheduler: RTL and testbench
=====================================

Name: ldpc_enc_scheduler

Overview:
- Sequences one Parity_generation_unit (PGU) instance over a full QC-LDPC message block.
- Buffers NCHUNK message words of Lm bits each.
- For every parity column p, reads the pre-rotated circulant rows (p,c) from an external ROM and streams {msg chunk, row} into the PGU.
- XOR-accumulates the PGU results into an M-bit parity register, then emits one M-bit parity word per column over a valid/ready handshake.
- Sits between the message source and the parity output FIFO of the encoder.

Parameters:
- Lm, 16, message bits per PGU pass (must match the PGU).
- M, 511, circulant size / parity word width.
- NCHUNK, 32, message words per block (≥1).
- NPAR, 8, parity circulant columns per block (≥1).
- PGU_LAT, 2, cycles from PGU input to a valid u_reg.
- ROM_AW, $clog2(NPAR*NCHUNK) (minimum 1), ROM address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset; also drives the PGU reset.
- start  in  1  pulse; begins a block when in IDLE, ignored otherwise.
- msg_data  in  Lm  message word.
- msg_valid  in  1  message word valid.
- msg_ready  out  1  accepting message words.
- rom_addr  out  ROM_AW  equals p*NCHUNK + c.
- rom_en  out  1  ROM read enable.
- rom_data  in  M  row read from ROM; valid one cycle after rom_en.
- pgu_msg  out  Lm  drives PGU msg_inp.
- pgu_f  out  M  drives PGU f_inp.
- pgu_u  in  M  PGU u_reg.
- par_data  out  M  parity word.
- par_valid  out  1  parity word valid.
- par_ready  in  1  downstream accepts.
- par_last  out  1  high with the final parity column.
- busy  out  1  high whenever not IDLE.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; counters 0; accumulator 0; valid pipe 0.
- Reset mid-operation: abandons the block immediately; no partial parity is emitted; the PGU resets in the same cycle.

State machine:
- IDLE: start → LOAD, with p=0 and the load index cleared.
- LOAD:
  - msg_ready=1.
  - On msg_valid&&msg_ready, write buf[idx]=msg_data and increment idx.
  - Gaps in msg_valid are allowed.
  - After word NCHUNK-1 is accepted → ISSUE, with c=0 and acc=0.
- ISSUE:
  - One ROM read per cycle: rom_en=1, rom_addr=p*NCHUNK+c.
  - Next cycle: pgu_f=rom_data, pgu_msg=buf[c] (buf index delayed one cycle), and a valid bit enters a PGU_LAT-deep shift pipe.
  - After c=NCHUNK-1 is issued → DRAIN.
- DRAIN: wait until the valid pipe and ROM stage are empty → OUT.
- Accumulation (all states):
  - When the pipe output is 1, acc <= acc ^ pgu_u.
  - pgu_msg and pgu_f are 0 whenever no valid issue, so PGU output for idle slots is 0.
- OUT:
  - par_data=acc, par_valid=1, par_last=(p==NPAR-1).
  - par_data is held stable while par_ready=0.
  - On handshake, if p==NPAR-1 → IDLE, else p++, c=0, acc=0 → ISSUE. The message buffer is reused.

Timing and widths:
- Latency from a column's first rom_en to par_valid is NCHUNK+1+PGU_LAT cycles.
- Counter widths: $clog2 of their range, minimum 1.
- rom_addr is computed without overflow in ROM_AW bits.

Boundary conditions:
- NCHUNK=1: LOAD takes a single word and ISSUE lasts one cycle.
- NPAR=1: par_last=1 on the only word.
- start during a busy block: ignored.
- par_ready=1 in the same cycle par_valid rises: handshake completes that cycle.

Optional Feature:
- Macro: ENC_STATS_EN.
- When defined: adds output frames_done (16 bits), incremented on each final par_last handshake. It wraps 0xFFFF→0 and resets to 0.
- When undefined: the port and its counter are absent; behaviour is otherwise identical.

Decomposition:
- Package ldpc_enc_pkg holds:
  - state enum (IDLE, LOAD, ISSUE, DRAIN, OUT);
  - PGU_LAT default;
  - a function computing ROM_AW.
- One natural sub-module, ldpc_enc_valid_pipe: PGU_LAT-deep valid shift register with empty flag.
- The PGU itself is instantiated by the encoder top level, not inside this block.

Test Plan:
Bench config: Lm=4, M=7, NCHUNK=2, NPAR=2, PGU_LAT=2, with a real PGU attached.
1. Basic block: msg {4'b0001, 4'b0000}; ROM(0,0)=7'h55, ROM(1,0)=7'h0F, other rows 0 → par_data 7'h55 then 7'h0F; par_last only on the second word.
2. Cancellation: msg {4'b0001, 4'b0001}; ROM(0,0)=ROM(0,1)=7'h55 → parity column 0 = 7'h00.
3. Rotation: msg {4'b0010, 0}; ROM(0,0)=7'h01 → parity column 0 = 7'h40.
4. Backpressure: par_ready held low for 5 cycles at the first column → par_data stable; no ROM reads; second column starts only after the handshake.
5. Stalls and start: msg_valid toggled every other cycle and start pulsed during ISSUE → result identical to scenario 1; the extra start is ignored.
6. Reset: rst asserted mid-ISSUE → next cycle busy=0 and par_valid=0; a following clean block matches scenario 1. With ENC_STATS_EN, frames_done=1 after that block.

Source files
------------

// File: rtl/ldpc_enc_pkg.sv
// Shared types and sizing helpers for the QC-LDPC encoder scheduler.
package ldpc_enc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        DRAIN,
        OUT
    } state_e;

    localparam int PGU_LAT_DEF = 2;

    // Counter/address width for a range of n values, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int rom_aw(input int npar, input int nchunk);
        return clog2_min1(npar * nchunk);
    endfunction

endpackage

// File: rtl/ldpc_enc_valid_pipe.sv
// Valid-bit shift register that tracks PGU passes in flight.
// empty is high when no bit would still be in flight after the coming edge
// (the output stage is being retired into the accumulator on that edge).
module ldpc_enc_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_in,
    output logic valid_out,
    output logic empty
);

    logic [DEPTH-1:0] pipe_q, pipe_d;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = valid_in;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        empty = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (pipe_q[i]) begin
                empty = 1'b0;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign valid_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/ldpc_enc_scheduler.sv
// Sequences one PGU over a QC-LDPC message block and emits one parity word per column.
// Optional macro ENC_STATS_EN adds a 16-bit frames_done counter output.
module ldpc_enc_scheduler
    import ldpc_enc_pkg::*;
#(
    parameter int Lm      = 16,
    parameter int M       = 511,
    parameter int NCHUNK  = 32,
    parameter int NPAR    = 8,
    parameter int PGU_LAT = PGU_LAT_DEF,
    parameter int ROM_AW  = rom_aw(NPAR, NCHUNK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [Lm-1:0]     msg_data,
    input  logic              msg_valid,
    output logic              msg_ready,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_en,
    input  logic [M-1:0]      rom_data,
    output logic [Lm-1:0]     pgu_msg,
    output logic [M-1:0]      pgu_f,
    input  logic [M-1:0]      pgu_u,
    output logic [M-1:0]      par_data,
    output logic              par_valid,
    input  logic              par_ready,
    output logic              par_last,
    output logic              busy
`ifdef ENC_STATS_EN
    ,
    output logic [15:0]       frames_done
`endif
);

    localparam int CW = clog2_min1(NCHUNK);
    localparam int PW = clog2_min1(NPAR);
    localparam logic [CW-1:0] C_LAST = CW'(NCHUNK - 1);
    localparam logic [PW-1:0] P_LAST = PW'(NPAR - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] c_q, c_d;
    logic [CW-1:0] cidx_q, cidx_d;
    logic [PW-1:0] p_q, p_d;
    logic          issue_q, issue_d;
    logic [M-1:0]  acc_q, acc_d;
    logic          msg_wr;
    logic          pipe_out;
    logic          pipe_empty;

    logic [Lm-1:0] msg_buf_q [NCHUNK];

    ldpc_enc_valid_pipe #(
        .DEPTH(PGU_LAT)
    ) u_valid_pipe (
        .clk      (clk),
        .rst      (rst),
        .valid_in (issue_q),
        .valid_out(pipe_out),
        .empty    (pipe_empty)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        c_d       = c_q;
        p_d       = p_q;
        cidx_d    = c_q;
        issue_d   = 1'b0;
        acc_d     = pipe_out ? (acc_q ^ pgu_u) : acc_q;
        msg_wr    = 1'b0;
        msg_ready = 1'b0;
        rom_en    = 1'b0;
        rom_addr  = '0;
        par_valid = 1'b0;
        par_data  = '0;
        par_last  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    p_d     = '0;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    msg_wr = 1'b1;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == C_LAST) begin
                        state_d = ISSUE;
                        idx_d   = '0;
                        c_d     = '0;
                        acc_d   = '0;
                    end
                end
            end
            ISSUE: begin
                rom_en   = 1'b1;
                rom_addr = ROM_AW'(p_q) * ROM_AW'(NCHUNK) + ROM_AW'(c_q);
                issue_d  = 1'b1;
                c_d      = c_q + 1'b1;
                if (c_q == C_LAST) begin
                    c_d     = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The last pass retires into acc on this edge, so acc is final in OUT.
                if (!issue_q && pipe_empty) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                par_valid = 1'b1;
                par_data  = acc_q;
                par_last  = (p_q == P_LAST);
                if (par_ready) begin
                    if (p_q == P_LAST) begin
                        state_d = IDLE;
                    end else begin
                        p_d     = p_q + 1'b1;
                        c_d     = '0;
                        acc_d   = '0;
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Idle slots feed zeros so the PGU contributes nothing to acc for them.
    assign pgu_msg = issue_q ? msg_buf_q[cidx_q] : '0;
    assign pgu_f   = issue_q ? rom_data : '0;
    assign busy    = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            c_q     <= '0;
            cidx_q  <= '0;
            p_q     <= '0;
            issue_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            cidx_q  <= cidx_d;
            p_q     <= p_d;
            issue_q <= issue_d;
            acc_q   <= acc_d;
        end
    end

    // NOTE: the message buffer is storage, not control state; it is always
    // written before it is read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (msg_wr) begin
            msg_buf_q[idx_q] <= msg_data;
        end
    end

`ifdef ENC_STATS_EN
    logic [15:0] frames_q, frames_d;

    always_comb begin
        frames_d = frames_q;
        if (state_q == OUT && par_ready && p_q == P_LAST) begin
            frames_d = frames_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q <= '0;
        end else begin
            frames_q <= frames_d;
        end
    end

    assign frames_done = frames_q;
`endif

endmodule

// File: tb/tb_ldpc_enc_scheduler.sv
// Self-checking bench for ldpc_enc_scheduler with a behavioural PGU and ROM attached.
module tb_ldpc_enc_scheduler;

    localparam int LM      = 4;
    localparam int M       = 7;
    localparam int NCHUNK  = 2;
    localparam int NPAR    = 2;
    localparam int PGU_LAT = 2;
    localparam int RAW     = 2;
    localparam int LAT     = NCHUNK + 1 + PGU_LAT;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [LM-1:0]  msg_data = '0;
    logic           msg_valid = 1'b0;
    logic           msg_ready;
    logic [RAW-1:0] rom_addr;
    logic           rom_en;
    logic [M-1:0]   rom_data;
    logic [LM-1:0]  pgu_msg;
    logic [M-1:0]   pgu_f;
    logic [M-1:0]   pgu_u;
    logic [M-1:0]   par_data;
    logic           par_valid;
    logic           par_ready = 1'b0;
    logic           par_last;
    logic           busy;
`ifdef ENC_STATS_EN
    logic [15:0]    frames_done;
`endif

    ldpc_enc_scheduler #(
        .Lm(LM), .M(M), .NCHUNK(NCHUNK), .NPAR(NPAR), .PGU_LAT(PGU_LAT), .ROM_AW(RAW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .msg_data (msg_data),
        .msg_valid(msg_valid),
        .msg_ready(msg_ready),
        .rom_addr (rom_addr),
        .rom_en   (rom_en),
        .rom_data (rom_data),
        .pgu_msg  (pgu_msg),
        .pgu_f    (pgu_f),
        .pgu_u    (pgu_u),
        .par_data (par_data),
        .par_valid(par_valid),
        .par_ready(par_ready),
        .par_last (par_last),
        .busy     (busy)
`ifdef ENC_STATS_EN
        ,
        .frames_done(frames_done)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM: row data appears one cycle after rom_en.
    logic [M-1:0] rom_mem [NPAR*NCHUNK];
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_mem[rom_addr];
    end

    // PGU: XOR of f rotated right by i for every set message bit i; two register stages.
    function automatic logic [M-1:0] pgu_fn(input logic [LM-1:0] m, input logic [M-1:0] f);
        logic [M-1:0]   r;
        logic [2*M-1:0] d;
        r = '0;
        d = {f, f};
        for (int i = 0; i < LM; i++) begin
            if (m[i]) r = r ^ M'(d >> i);
        end
        return r;
    endfunction

    logic [M-1:0] pgu_s1;
    always @(posedge clk) begin
        if (rst) begin
            pgu_s1 <= '0;
            pgu_u  <= '0;
        end else begin
            pgu_s1 <= pgu_fn(pgu_msg, pgu_f);
            pgu_u  <= pgu_s1;
        end
    end

    // Reference: parity bit j of column p is the GF(2) sum over chunks c and
    // message bits i of msg[c][i] & row(p,c)[(j+i) mod M].
    logic [LM-1:0] msg_arr [NCHUNK];
    logic [M-1:0]  obs_par [NPAR];

    function automatic logic [M-1:0] ref_parity(input int p);
        logic [M-1:0] r;
        logic [M-1:0] row;
        r = '0;
        for (int j = 0; j < M; j++) begin
            for (int c = 0; c < NCHUNK; c++) begin
                row = rom_mem[p*NCHUNK + c];
                for (int i = 0; i < LM; i++) begin
                    r[j] = r[j] ^ (msg_arr[c][i] & row[(j + i) % M]);
                end
            end
        end
        return r;
    endfunction

    int n_total = 0;
    int n_pass  = 0;
    int frames_exp = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_rom(input logic [M-1:0] r0, input logic [M-1:0] r1,
                           input logic [M-1:0] r2, input logic [M-1:0] r3);
        rom_mem[0] = r0;
        rom_mem[1] = r1;
        rom_mem[2] = r2;
        rom_mem[3] = r3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        frames_exp = 0;
    endtask

    task automatic start_and_load(input bit stall);
        int w;
        int tmo;
        bit tog;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        w = 0;
        tmo = 0;
        tog = 1'b0;
        while (w < NCHUNK && tmo < 100) begin
            msg_valid = stall ? tog : 1'b1;
            tog = ~tog;
            msg_data = msg_arr[w];
            if (msg_valid && msg_ready) w++;
            tmo++;
            @(negedge clk);
        end
        msg_valid = 1'b0;
        check("load_words_accepted", w, NCHUNK);
    endtask

    task automatic run_block(input bit stall, input bit start_in_issue, input int bp_first,
                             input bit rand_bp);
        logic [M-1:0] exp;
        int first_en;
        int n;
        int bp;
        start_and_load(stall);
        for (int p = 0; p < NPAR; p++) begin
            exp = ref_parity(p);
            bp = (p == 0) ? bp_first : 0;
            if (rand_bp) bp = int'($urandom_range(0, 3));
            par_ready = (bp == 0);
            first_en = -1;
            n = 0;
            while (!par_valid && n < 40) begin
                if (rom_en && first_en < 0) begin
                    first_en = cyc;
                    start = start_in_issue && (p == 0);
                end else begin
                    start = 1'b0;
                end
                n++;
                @(negedge clk);
            end
            start = 1'b0;
            check("par_valid_seen", par_valid, 1);
            check("col_latency", cyc - first_en, LAT);
            check("par_data", par_data, exp);
            check("par_last", par_last, (p == NPAR - 1));
            obs_par[p] = par_data;
            for (int k = 0; k < bp; k++) begin
                @(negedge clk);
                check("bp_data_stable", par_data, exp);
                check("bp_no_rom_read", rom_en, 0);
            end
            par_ready = 1'b1;
            @(negedge clk);
            par_ready = 1'b0;
            check("valid_drops_after_hs", par_valid, 0);
            if (p == NPAR - 1) check("idle_after_block", busy, 0);
            else check("next_col_reads_rom", rom_en, 1);
        end
        frames_exp++;
`ifdef ENC_STATS_EN
        check("frames_done", frames_done, frames_exp);
`endif
    endtask

    initial begin
        int n;
        int seen;

        // Reset state
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_par_valid", par_valid, 0);
        check("rst_par_last", par_last, 0);
        check("rst_par_data", par_data, 0);
        check("rst_msg_ready", msg_ready, 0);
        check("rst_rom_en", rom_en, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_pgu_msg", pgu_msg, 0);
        check("rst_pgu_f", pgu_f, 0);
`ifdef ENC_STATS_EN
        check("rst_frames_done", frames_done, 0);
`endif

        // 1. Basic block
        set_rom(7'h55, 7'h00, 7'h0F, 7'h00);
        msg_arr[0] = 4'b0001;
        msg_arr[1] = 4'b0000;
        run_block(1'b0, 1'b0, 0, 1'b0);
        check("s1_col0", obs_par[0], 7'h55);
        check("s1_col1", obs_par[1], 7'h0F);

        // 2. Cancellation
        set_rom(7'h55, 7'h55, 7'h0F, 7'h00);
        msg_arr[0] = 4'b0001;
        msg_arr[1] = 4'b0001;
        run_block(1'b0, 1'b0, 0, 1'b0);
        check("s2_col0", obs_par[0], 7'h00);

        // 3. Rotation
        set_rom(7'h01, 7'h00, 7'h00, 7'h00);
        msg_arr[0] = 4'b0010;
        msg_arr[1] = 4'b0000;
        run_block(1'b0, 1'b0, 0, 1'b0);
        check("s3_col0", obs_par[0], 7'h40);

        // 4. Backpressure on the first column
        set_rom(7'h55, 7'h00, 7'h0F, 7'h00);
        msg_arr[0] = 4'b0001;
        msg_arr[1] = 4'b0000;
        run_block(1'b0, 1'b0, 5, 1'b0);
        check("s4_col0", obs_par[0], 7'h55);
        check("s4_col1", obs_par[1], 7'h0F);

        // 5. Message stalls plus a stray start during ISSUE
        run_block(1'b1, 1'b1, 0, 1'b0);
        check("s5_col0", obs_par[0], 7'h55);
        check("s5_col1", obs_par[1], 7'h0F);
        repeat (3) @(negedge clk);
        check("s5_start_ignored", busy, 0);

        // 6. Reset in the middle of ISSUE, then a clean block
        start_and_load(1'b0);
        n = 0;
        while (!rom_en && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("s6_in_issue", rom_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        frames_exp = 0;
        check("s6_busy_after_rst", busy, 0);
        check("s6_valid_after_rst", par_valid, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (par_valid) seen++;
        end
        check("s6_no_partial_parity", seen, 0);
        run_block(1'b0, 1'b0, 0, 1'b0);
        check("s6_col0", obs_par[0], 7'h55);
        check("s6_col1", obs_par[1], 7'h0F);

        // Randomized blocks against the reference model
        for (int b = 0; b < 8; b++) begin
            for (int a = 0; a < NPAR*NCHUNK; a++) rom_mem[a] = M'($urandom);
            for (int c = 0; c < NCHUNK; c++) msg_arr[c] = LM'($urandom);
            run_block(1'($urandom_range(0, 1)), 1'b0, 0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
